// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: state encoding, default widths and table entry layout for tone_seq_ctrl.
// ST_GAP is only reachable when TONE_SEQ_GAP_EN is defined.
package tone_seq_pkg;

  localparam int NSTEPS_DEF  = 8;
  localparam int DIV_W_DEF   = 16;
  localparam int DUR_W_DEF   = 12;
  localparam int TICK_SH_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIN  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  typedef struct packed {
    logic [DIV_W_DEF-1:0] half;
    logic [DUR_W_DEF-1:0] dur;
  } step_t;

endpackage

// File: rtl/tone_seq_ctrl_div_core.sv
// tone_div_core: half-period counter plus toggle flop producing the divided square wave.
// load_i clears counter and wave; a zero half-period holds the wave low (rest).
module tone_div_core #(
  parameter int DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] half_i,
  output logic             wave_o
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wave_q, wave_d;

  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (load_i) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (enable_i && (half_i != '0)) begin
      if (cnt_q == half_i - CNT_ONE) begin
        cnt_d  = '0;
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave_o = wave_q;

endmodule

// File: rtl/tone_seq_ctrl.sv
// tone_seq_ctrl: plays a table of (half-period, duration) steps as a divided square wave.
// Defining TONE_SEQ_GAP_EN inserts a one-tick rest (ST_GAP) between consecutive steps.
//
//   state   | meaning
//   IDLE    | waiting for start; table writable
//   LOAD    | fetch entry[step_idx]; end marker -> FIN
//   RUN     | wave running, tick/duration counting
//   GAP     | one-tick rest before the next LOAD (TONE_SEQ_GAP_EN only)
//   FIN     | one-cycle done pulse
module tone_seq_ctrl
  import tone_seq_pkg::*;
#(
  parameter int NSTEPS  = NSTEPS_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DUR_W   = DUR_W_DEF,
  parameter int TICK_SH = TICK_SH_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [$clog2(NSTEPS)-1:0] cfg_addr,
  input  logic [DIV_W-1:0]          cfg_half,
  input  logic [DUR_W-1:0]          cfg_dur,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NSTEPS)-1:0] step_idx,
  output logic                      wave_out
);

  localparam int AW = $clog2(NSTEPS);
  localparam logic [AW-1:0]      IDX_ONE  = AW'(1);
  localparam logic [AW-1:0]      IDX_LAST = AW'(NSTEPS - 1);
  localparam logic [DUR_W-1:0]   DUR_ONE  = DUR_W'(1);
  localparam logic [TICK_SH-1:0] TICK_ONE = TICK_SH'(1);

  typedef struct packed {
    logic [DIV_W-1:0] half;
    logic [DUR_W-1:0] dur;
  } entry_t;

  entry_t tbl_q [NSTEPS];
  entry_t cur_entry;

  state_e             state_q, state_d;
  logic [AW-1:0]      step_idx_q, step_idx_d;
  logic               loop_q, loop_d;
  logic [DIV_W-1:0]   half_q, half_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
  logic [TICK_SH-1:0] tick_cnt_q, tick_cnt_d;
  logic               tick, last_step, step_end, seq_end;
  logic               div_load, div_en;

  // Table is frozen outside IDLE and deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (cfg_we && (state_q == ST_IDLE)) begin
      tbl_q[cfg_addr] <= {cfg_half, cfg_dur};
    end
  end

  assign cur_entry = tbl_q[step_idx_q];
  assign tick      = &tick_cnt_q;
  assign last_step = (step_idx_q == IDX_LAST);
  // Step ends on the tick that brings the duration count up to dur.
  assign step_end  = (state_q == ST_RUN) && tick && ((dur_cnt_q + DUR_ONE) == dur_q);
  assign seq_end   = last_step && !loop_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_LOAD;
      ST_LOAD: state_d = (cur_entry.dur == '0) ? ST_FIN : ST_RUN;
      ST_RUN: begin
        if (step_end) begin
          if (seq_end) begin
            state_d = ST_FIN;
          end else begin
`ifdef TONE_SEQ_GAP_EN
            state_d = ST_GAP;
`else
            state_d = ST_LOAD;
`endif
          end
        end
      end
`ifdef TONE_SEQ_GAP_EN
      ST_GAP: if (tick) state_d = ST_LOAD;
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (stop && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_LOAD, ST_RUN, ST_GAP: busy = 1'b1;
      ST_FIN:                  done = 1'b1;
      default: ;
    endcase
    div_en   = (state_q == ST_RUN);
    div_load = !div_en || step_end || stop;
  end

  always_comb begin
    step_idx_d = step_idx_q;
    loop_d     = loop_q;
    half_d     = half_q;
    dur_d      = dur_q;
    dur_cnt_d  = dur_cnt_q;
    tick_cnt_d = tick_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          step_idx_d = '0;
          loop_d     = loop;
        end
      end
      ST_LOAD: begin
        half_d     = cur_entry.half;
        dur_d      = cur_entry.dur;
        dur_cnt_d  = '0;
        tick_cnt_d = '0;
      end
      ST_RUN: begin
        tick_cnt_d = tick_cnt_q + TICK_ONE;
        if (tick) dur_cnt_d = dur_cnt_q + DUR_ONE;
        if (step_end && !seq_end) step_idx_d = last_step ? '0 : step_idx_q + IDX_ONE;
      end
      ST_GAP: tick_cnt_d = tick_cnt_q + TICK_ONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      step_idx_q <= '0;
      loop_q     <= 1'b0;
      half_q     <= '0;
      dur_q      <= '0;
      dur_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      step_idx_q <= step_idx_d;
      loop_q     <= loop_d;
      half_q     <= half_d;
      dur_q      <= dur_d;
      dur_cnt_q  <= dur_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  tone_div_core #(.DIV_W(DIV_W)) u_div (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load_i   (div_load),
    .enable_i (div_en),
    .half_i   (half_q),
    .wave_o   (wave_out)
  );

  assign step_idx = step_idx_q;

endmodule

// File: tb/tb_tone_seq_ctrl.sv
// Directed bench for tone_seq_ctrl (TICK_SH=2): an 8-step instance and a 2-step looping instance.
module tb_tone_seq_ctrl;

  localparam int TB_TICK_SH = 2;
`ifdef TONE_SEQ_GAP_EN
  localparam int G = 1 << TB_TICK_SH;
`else
  localparam int G = 0;
`endif
  localparam int NB = 17 + 2 * G;
  localparam int P  = 5 + G;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        cfg_we, start, stop, loop;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_half;
  logic [11:0] cfg_dur;
  logic        busy, done, wave_out;
  logic [2:0]  step_idx;

  logic        cfg_we2, start2, stop2, loop2;
  logic [0:0]  cfg_addr2;
  logic [15:0] cfg_half2;
  logic [11:0] cfg_dur2;
  logic        busy2, done2, wave2;
  logic [0:0]  step_idx2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_in = ~clk_in;

  tone_seq_ctrl #(.NSTEPS(8), .DIV_W(16), .DUR_W(12), .TICK_SH(TB_TICK_SH)) u_dut (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_half(cfg_half), .cfg_dur(cfg_dur), .start(start), .stop(stop), .loop(loop),
    .busy(busy), .done(done), .step_idx(step_idx), .wave_out(wave_out)
  );

  tone_seq_ctrl #(.NSTEPS(2), .DIV_W(16), .DUR_W(12), .TICK_SH(TB_TICK_SH)) u_dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_we(cfg_we2), .cfg_addr(cfg_addr2),
    .cfg_half(cfg_half2), .cfg_dur(cfg_dur2), .start(start2), .stop(stop2), .loop(loop2),
    .busy(busy2), .done(done2), .step_idx(step_idx2), .wave_out(wave2)
  );

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr1(input int a, input int h, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_half = 16'(h);
    cfg_dur  = 12'(d);
    cyc();
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    nvec++;
    if ({busy, done, wave_out, step_idx} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_dut1 {busy,done,wave,idx} got %b want 000000", {busy, done, wave_out, step_idx});
    end
    nvec++;
    if ({busy2, done2, wave2, step_idx2} !== 4'b0) begin
      nerr++;
      $display("FAIL reset_dut2 {busy,done,wave,idx} got %b want 0000", {busy2, done2, wave2, step_idx2});
    end
    rst_n = 1'b1;
    cyc();
    nvec++;
    if ({busy, done, wave_out} !== 3'b0) begin
      nerr++;
      $display("FAIL reset_idle {busy,done,wave} got %b want 000", {busy, done, wave_out});
    end
  endtask

  task automatic test_basic();
    logic [5:0] got, want;
    logic [2:0] ei;
    wr1(0, 3, 2);
    wr1(1, 0, 1);
    wr1(2, 7, 0);
    loop  = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      ei   = (k <= 8) ? 3'd0 : (k <= 13 + G) ? 3'd1 : 3'd2;
      want = {logic'(k <= 14 + 2 * G), logic'(k == 15 + 2 * G), logic'(k >= 4 && k <= 6), ei};
      got  = {busy, done, wave_out, step_idx};
      nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL basic k=%0d {busy,done,wave,idx} got %b want %b", k, got, want);
      end
      cyc();
    end
  endtask

  task automatic test_dead();
    logic [5:0] got, want;
    // entry 0 rewritten as an end marker in the same cycle start is issued
    cfg_we   = 1'b1;
    cfg_addr = 3'd0;
    cfg_half = 16'd5;
    cfg_dur  = 12'd0;
    start    = 1'b1;
    cyc();
    cfg_we = 1'b0;
    start  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      want = {logic'(k == 0), logic'(k == 1), 1'b0, 3'd0};
      got  = {busy, done, wave_out, step_idx};
      nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL dead k=%0d {busy,done,wave,idx} got %b want %b", k, got, want);
      end
      cyc();
    end
  endtask

  task automatic test_busy_ignore();
    logic [5:0] got, want;
    logic [2:0] ei;
    wr1(0, 3, 2);
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < NB; k++) begin
        ei   = (k <= 8) ? 3'd0 : (k <= 13 + G) ? 3'd1 : 3'd2;
        want = {logic'(k <= 14 + 2 * G), logic'(k == 15 + 2 * G), logic'(k >= 4 && k <= 6), ei};
        got  = {busy, done, wave_out, step_idx};
        nvec++;
        if (got !== want) begin
          nerr++;
          $display("FAIL busy_ignore run=%0d k=%0d {busy,done,wave,idx} got %b want %b", r, k, got, want);
        end
        if (r == 0 && k == 2) begin
          cfg_we   = 1'b1;
          cfg_addr = 3'd0;
          cfg_half = 16'd1;
          cfg_dur  = 12'd0;
          start    = 1'b1;
        end
        cyc();
        cfg_we = 1'b0;
        start  = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] got, want;
    logic [2:0] ei;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    nvec++;
    if ({busy, wave_out} !== 2'b11) begin
      nerr++;
      $display("FAIL reset_mid_pre {busy,wave} got %b want 11", {busy, wave_out});
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    nvec++;
    if ({busy, done, wave_out, step_idx} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_mid_post {busy,done,wave,idx} got %b want 000000", {busy, done, wave_out, step_idx});
    end
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      ei   = (k <= 8) ? 3'd0 : (k <= 13 + G) ? 3'd1 : 3'd2;
      want = {logic'(k <= 14 + 2 * G), logic'(k == 15 + 2 * G), logic'(k >= 4 && k <= 6), ei};
      got  = {busy, done, wave_out, step_idx};
      nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL reset_mid_replay k=%0d {busy,done,wave,idx} got %b want %b", k, got, want);
      end
      cyc();
    end
  endtask

  task automatic test_gap();
    logic [2:0] got, want;
    logic       ew;
    wr1(0, 1, 1);
    wr1(1, 1, 1);
    wr1(2, 0, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 13 + 2 * G; k++) begin
      ew   = (k == 2) || (k == 4) || (k == 7 + G) || (k == 9 + G);
      want = {logic'(k <= 10 + 2 * G), logic'(k == 11 + 2 * G), ew};
      got  = {busy, done, wave_out};
      nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL gap k=%0d {busy,done,wave} got %b want %b", k, got, want);
      end
      cyc();
    end
  endtask

  task automatic test_loop();
    logic [3:0] got, want;
    logic       ei, ew;
    int         m;
    cfg_we2   = 1'b1;
    cfg_addr2 = 1'b0;
    cfg_half2 = 16'd2;
    cfg_dur2  = 12'd1;
    cyc();
    cfg_addr2 = 1'b1;
    cfg_half2 = 16'd1;
    cyc();
    cfg_we2 = 1'b0;
    loop2   = 1'b1;
    start2  = 1'b1;
    cyc();
    start2 = 1'b0;
    loop2  = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      m    = k % (2 * P);
      ei   = (m >= 5) && (m < 5 + P);
      ew   = (m < P) ? ((m == 3) || (m == 4)) : ((m - P == 2) || (m - P == 4));
      want = {1'b1, 1'b0, ew, ei};
      got  = {busy2, done2, wave2, step_idx2};
      nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL loop k=%0d {busy,done,wave,idx} got %b want %b", k, got, want);
      end
      if (k < 50) cyc();
    end
    stop2 = 1'b1;
    cyc();
    stop2 = 1'b0;
    nvec++;
    if ({busy2, done2, wave2} !== 3'b0) begin
      nerr++;
      $display("FAIL loop_stop {busy,done,wave} got %b want 000", {busy2, done2, wave2});
    end
    cyc();
    nvec++;
    if ({busy2, done2} !== 2'b0) begin
      nerr++;
      $display("FAIL loop_after_stop {busy,done} got %b want 00", {busy2, done2});
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = 3'd0;
    cfg_half  = 16'd0;
    cfg_dur   = 12'd0;
    start     = 1'b0;
    stop      = 1'b0;
    loop      = 1'b0;
    cfg_we2   = 1'b0;
    cfg_addr2 = 1'b0;
    cfg_half2 = 16'd0;
    cfg_dur2  = 12'd0;
    start2    = 1'b0;
    stop2     = 1'b0;
    loop2     = 1'b0;
    test_reset();
    test_basic();
    test_dead();
    test_busy_ignore();
    test_reset_mid();
    test_gap();
    test_loop();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
